// File: rtl/tl45_writeback.sv
// tl45 writeback: arbitrates ALU and memory results onto the register-file write port,
// keeps the RAW pending scoreboard and a one-entry ALU skid buffer. Option: TL45_WB_FORWARD_EN.
module tl45_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [3:0]  i_alu_dr,
    input  logic [31:0] i_alu_value,
    input  logic        i_mem_valid,
    input  logic [3:0]  i_mem_dr,
    input  logic [31:0] i_mem_value,
    input  logic        i_issue_valid,
    input  logic [3:0]  i_issue_dr,
    output logic [15:0] o_busy,
    output logic        o_rf_wr,
    output logic [3:0]  o_rf_addr,
    output logic [31:0] o_rf_data,
    output logic        o_fwd_valid,
    output logic [3:0]  o_fwd_addr,
    output logic [31:0] o_fwd_data
);

    logic        buf_valid;
    logic [3:0]  buf_dr;
    logic [31:0] buf_value;
    logic [15:0] busy;
    logic        rf_wr;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;

    logic        alu_accept;
    logic        win_valid;
    logic [3:0]  win_dr;
    logic [31:0] win_value;
    logic        win_write;
    logic        issue_set;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    logic [15:0] busy_next;

    assign o_alu_ready = !buf_valid;
    assign alu_accept  = i_alu_valid && !buf_valid;

    // Memory cannot stall, so it always wins; the buffer drains ahead of fresh ALU results.
    always_comb begin
        win_valid = 1'b0;
        win_dr    = 4'd0;
        win_value = 32'd0;
        if (i_mem_valid) begin
            win_valid = 1'b1;
            win_dr    = i_mem_dr;
            win_value = i_mem_value;
        end else if (buf_valid) begin
            win_valid = 1'b1;
            win_dr    = buf_dr;
            win_value = buf_value;
        end else if (alu_accept) begin
            win_valid = 1'b1;
            win_dr    = i_alu_dr;
            win_value = i_alu_value;
        end
    end

    assign win_write = win_valid && (win_dr != 4'd0);
    assign issue_set = i_issue_valid && (i_issue_dr != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_dr    <= 4'd0;
            buf_value <= 32'd0;
        end else if (i_mem_valid && alu_accept) begin
            buf_valid <= 1'b1;
            buf_dr    <= i_alu_dr;
            buf_value <= i_alu_value;
        end else if (!i_mem_valid && buf_valid) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr   <= 1'b0;
            rf_addr <= 4'd0;
            rf_data <= 32'd0;
        end else begin
            rf_wr <= win_write;
            if (win_write) begin
                rf_addr <= win_dr;
                rf_data <= win_value;
            end
        end
    end

`ifdef TL45_WB_FORWARD_EN
    logic fwd_on;

    assign clr_mask    = win_write ? (16'd1 << win_dr) : 16'd0;
    assign fwd_on      = win_write && !reset;
    assign o_fwd_valid = fwd_on;
    assign o_fwd_addr  = fwd_on ? win_dr : 4'd0;
    assign o_fwd_data  = fwd_on ? win_value : 32'd0;
`else
    // Without bypass the clear waits for the register-file commit; a re-issue
    // of the same register in the winning cycle cancels the deferred clear.
    logic       clr_pend;
    logic [3:0] clr_dr;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_pend <= 1'b0;
            clr_dr   <= 4'd0;
        end else begin
            clr_pend <= win_write && !(issue_set && (i_issue_dr == win_dr));
            clr_dr   <= win_dr;
        end
    end

    assign clr_mask    = clr_pend ? (16'd1 << clr_dr) : 16'd0;
    assign o_fwd_valid = 1'b0;
    assign o_fwd_addr  = 4'd0;
    assign o_fwd_data  = 32'd0;
`endif

    assign set_mask  = issue_set ? (16'd1 << i_issue_dr) : 16'd0;
    assign busy_next = ((busy & ~clr_mask) | set_mask) & 16'hFFFE;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 16'd0;
        end else begin
            busy <= busy_next;
        end
    end

    assign o_busy    = busy;
    assign o_rf_wr   = rf_wr;
    assign o_rf_addr = rf_addr;
    assign o_rf_data = rf_data;

endmodule

// File: tb/tb_tl45_writeback.sv
// Bench for tl45_writeback: directed literal cases, then randomized traffic checked each
// cycle against a queue-based model of arbitration, skid buffer and scoreboard.
module tb_tl45_writeback;

`ifdef TL45_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [3:0]  i_alu_dr;
    logic [31:0] i_alu_value;
    logic        i_mem_valid;
    logic [3:0]  i_mem_dr;
    logic [31:0] i_mem_value;
    logic        i_issue_valid;
    logic [3:0]  i_issue_dr;
    logic [15:0] o_busy;
    logic        o_rf_wr;
    logic [3:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic        o_fwd_valid;
    logic [3:0]  o_fwd_addr;
    logic [31:0] o_fwd_data;

    tl45_writeback dut (
        .clk(clk), .reset(reset),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_dr(i_alu_dr), .i_alu_value(i_alu_value),
        .i_mem_valid(i_mem_valid), .i_mem_dr(i_mem_dr), .i_mem_value(i_mem_value),
        .i_issue_valid(i_issue_valid), .i_issue_dr(i_issue_dr),
        .o_busy(o_busy), .o_rf_wr(o_rf_wr), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
        .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_data(o_fwd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: ALU results waiting behind memory, expected write port, scoreboard.
    logic [35:0] mq[$];
    logic        m_wr;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_busy;
    logic [15:0] m_sched;
    bit          alu_taken;
    logic [15:0] in_exec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit          acc;
        bit          w;
        logic [3:0]  wd;
        logic [31:0] wv;
        logic [15:0] wb;
        logic [15:0] ib;
        if (reset) begin
            mq.delete();
            m_wr = 1'b0; m_addr = 4'd0; m_data = 32'd0;
            m_busy = 16'd0; m_sched = 16'd0;
            alu_taken = 1'b0;
            return;
        end
        acc = i_alu_valid && (mq.size() == 0);
        w = 1'b0; wd = 4'd0; wv = 32'd0;
        if (i_mem_valid) begin
            w = 1'b1; wd = i_mem_dr; wv = i_mem_value;
            if (acc) mq.push_back({i_alu_dr, i_alu_value});
        end else if (mq.size() > 0) begin
            {wd, wv} = mq.pop_front();
            w = 1'b1;
        end else if (acc) begin
            w = 1'b1; wd = i_alu_dr; wv = i_alu_value;
        end
        alu_taken = acc;
        wb = (w && wd != 4'd0) ? (16'd1 << wd) : 16'd0;
        ib = (i_issue_valid && i_issue_dr != 4'd0) ? (16'd1 << i_issue_dr) : 16'd0;
        if (FWD) begin
            m_busy = m_busy & ~wb;
        end else begin
            m_busy  = m_busy & ~m_sched;
            m_sched = wb & ~ib;
        end
        m_busy = (m_busy | ib) & 16'hFFFE;
        m_wr = (wb != 16'd0);
        if (m_wr) begin
            m_addr = wd;
            m_data = wv;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        i_alu_valid = 1'b0; i_alu_dr = 4'd0; i_alu_value = 32'd0;
        i_mem_valid = 1'b0; i_mem_dr = 4'd0; i_mem_value = 32'd0;
        i_issue_valid = 1'b0; i_issue_dr = 4'd0;
    endtask

    function automatic int pick(input logic [15:0] v);
        int s;
        int r;
        s = $urandom_range(15, 1);
        for (int k = 0; k < 15; k++) begin
            r = 1 + ((s - 1 + k) % 15);
            if (v[r]) return r;
        end
        return 0;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit          w;
        logic [3:0]  wd;
        logic [31:0] wv;
        bit          fv;
        if (chk_en && !reset) begin
            chk("rf_wr", o_rf_wr, m_wr);
            chk("rf_addr", o_rf_addr, m_addr);
            chk("rf_data", o_rf_data, m_data);
            chk("busy", o_busy, m_busy);
            chk("alu_ready", o_alu_ready, mq.size() == 0);
            w = 1'b0; wd = 4'd0; wv = 32'd0;
            if (i_mem_valid) begin
                w = 1'b1; wd = i_mem_dr; wv = i_mem_value;
            end else if (mq.size() > 0) begin
                w = 1'b1; {wd, wv} = mq[0];
            end else if (i_alu_valid) begin
                w = 1'b1; wd = i_alu_dr; wv = i_alu_value;
            end
            fv = FWD && w && (wd != 4'd0);
            chk("fwd_valid", o_fwd_valid, fv);
            chk("fwd_addr", o_fwd_addr, fv ? wd : 4'd0);
            chk("fwd_data", o_fwd_data, fv ? wv : 32'd0);
            if (i_issue_valid && i_issue_dr != 4'd0)
                chk("issue_to_busy", o_busy[i_issue_dr], 1'b0);
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        in_exec = 16'd0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_rf_wr", o_rf_wr, 1'b0);
        chk("rst_rf_addr", o_rf_addr, 4'd0);
        chk("rst_rf_data", o_rf_data, 32'd0);
        chk("rst_busy", o_busy, 16'd0);
        chk("rst_ready", o_alu_ready, 1'b1);
        chk("rst_fwd_valid", o_fwd_valid, 1'b0);
        chk("rst_fwd_addr", o_fwd_addr, 4'd0);
        chk("rst_fwd_data", o_fwd_data, 32'd0);
        chk_en = 1'b1;
        cyc();

        // single ALU result
        i_alu_valid = 1'b1; i_alu_dr = 4'd3; i_alu_value = 32'hDEADBEEF;
        #1;
        chk("t2_ready_n", o_alu_ready, 1'b1);
        chk("t2_fwd_valid", o_fwd_valid, FWD);
        cyc();
        idle();
        chk("t2_wr", o_rf_wr, 1'b1);
        chk("t2_addr", o_rf_addr, 4'd3);
        chk("t2_data", o_rf_data, 32'hDEADBEEF);
        chk("t2_ready", o_alu_ready, 1'b1);

        // mem/ALU collision
        i_mem_valid = 1'b1; i_mem_dr = 4'd5; i_mem_value = 32'h11;
        i_alu_valid = 1'b1; i_alu_dr = 4'd6; i_alu_value = 32'h22;
        cyc();
        idle();
        chk("t3_wr1", o_rf_wr, 1'b1);
        chk("t3_addr1", o_rf_addr, 4'd5);
        chk("t3_data1", o_rf_data, 32'h11);
        chk("t3_ready1", o_alu_ready, 1'b0);
        cyc();
        chk("t3_wr2", o_rf_wr, 1'b1);
        chk("t3_addr2", o_rf_addr, 4'd6);
        chk("t3_data2", o_rf_data, 32'h22);
        chk("t3_ready2", o_alu_ready, 1'b1);
        cyc();

        // scoreboard set and clear for R7
        i_issue_valid = 1'b1; i_issue_dr = 4'd7;
        cyc();
        idle();
        chk("t4_busy_set", o_busy, 16'h0080);
        i_alu_valid = 1'b1; i_alu_dr = 4'd7; i_alu_value = 32'h77;
        #1;
        chk("t4_fwd_addr", o_fwd_addr, FWD ? 4'd7 : 4'd0);
        chk("t4_fwd_data", o_fwd_data, FWD ? 32'h77 : 32'd0);
        cyc();
        idle();
        chk("t4_wr", o_rf_wr, 1'b1);
        chk("t4_addr", o_rf_addr, 4'd7);
        chk("t4_busy_n1", o_busy, FWD ? 16'h0000 : 16'h0080);
        cyc();
        chk("t4_busy_n2", o_busy, 16'h0000);
        chk("t4_wr_idle", o_rf_wr, 1'b0);
        chk("t4_addr_hold", o_rf_addr, 4'd7);

        // R0 writes and issues are ignored
        i_issue_valid = 1'b1; i_issue_dr = 4'd0;
        i_alu_valid = 1'b1; i_alu_dr = 4'd0; i_alu_value = 32'hFFFFFFFF;
        cyc();
        idle();
        chk("t5_wr", o_rf_wr, 1'b0);
        chk("t5_busy", o_busy, 16'h0000);
        chk("t5_data_hold", o_rf_data, 32'h77);
        cyc();
        chk("t5_wr2", o_rf_wr, 1'b0);

        // issue and writeback of R4 in the same cycle: set wins
        i_issue_valid = 1'b1; i_issue_dr = 4'd4;
        i_alu_valid = 1'b1; i_alu_dr = 4'd4; i_alu_value = 32'h44;
        cyc();
        idle();
        chk("t6_busy1", o_busy, 16'h0010);
        chk("t6_addr", o_rf_addr, 4'd4);
        cyc();
        chk("t6_busy2", o_busy, 16'h0010);
        cyc();
        chk("t6_busy3", o_busy, 16'h0010);

        // buffered result discarded by reset
        i_issue_valid = 1'b1; i_issue_dr = 4'd10;
        cyc();
        idle();
        i_mem_valid = 1'b1; i_mem_dr = 4'd9; i_mem_value = 32'h99;
        i_alu_valid = 1'b1; i_alu_dr = 4'd10; i_alu_value = 32'hAA;
        cyc();
        idle();
        chk("t7_ready_full", o_alu_ready, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t7_wr", o_rf_wr, 1'b0);
        chk("t7_busy", o_busy, 16'h0000);
        chk("t7_ready", o_alu_ready, 1'b1);
        chk("t7_addr", o_rf_addr, 4'd0);
        cyc();
        chk("t7_no_buf_write", o_rf_wr, 1'b0);

        // randomized traffic: results only for issued registers (plus R0 noise)
        in_exec = 16'd0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (alu_taken) i_alu_valid = 1'b0;
            i_mem_valid = 1'b0;
            i_issue_valid = 1'b0;
            if ($urandom_range(99) < 35) begin
                r = ($urandom_range(9) == 0) ? 0 : pick(in_exec);
                if (r != 0 || $urandom_range(3) == 0) begin
                    i_mem_valid = 1'b1; i_mem_dr = 4'(r); i_mem_value = $urandom;
                    in_exec[r] = 1'b0;
                end
            end
            if (!i_alu_valid && $urandom_range(99) < 45) begin
                r = ($urandom_range(9) == 0) ? 0 : pick(in_exec);
                if (r != 0 || $urandom_range(3) == 0) begin
                    i_alu_valid = 1'b1; i_alu_dr = 4'(r); i_alu_value = $urandom;
                    in_exec[r] = 1'b0;
                end
            end
            if ($urandom_range(99) < 45) begin
                r = ($urandom_range(19) == 0) ? 0 : pick(~m_busy & ~in_exec);
                i_issue_valid = 1'b1; i_issue_dr = 4'(r);
                if (r != 0) in_exec[r] = 1'b1;
            end
            in_exec[0] = 1'b0;
            cyc();
        end
        idle();
        repeat (4) cyc();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
